pwm_ctl_mc: RTL and testbench
=============================

PWM_CTL_MC -- requirements
Module: pwm_ctl_mc

Interface
REQ-001 SHALL provide parameter NCH, default 4: number of independent off-time channels.
REQ-002 SHALL provide parameter CNT_WIDTH, default 18: width of each off_div value.
REQ-003 SHALL provide parameter SUM_WIDTH, default 37: width of the two's-complement error sum.
REQ-004 SHALL provide parameter SHIFT, default 10: right-shift that scales |sum| to a step.
REQ-005 SHALL provide parameter MAX_STEP, default 64: normal-mode step magnitude limit.
REQ-006 SHALL provide parameter SS_STEP, default 2: soft-start step magnitude limit.
REQ-007 SHALL provide parameter START_OFF, default 100: reset and reload value of off_div.
REQ-008 SHALL provide parameters MIN_OFF, default 1, and TOTAL_TIME, default 400: clamp bounds.
REQ-009 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-010 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-011 SHALL have port upd_valid, input, 1 bit: update request.
REQ-012 SHALL have port upd_ch, input, CW = max(1,$clog2(NCH)) bits: target channel.
REQ-013 SHALL have port sum, input, SUM_WIDTH bits: signed error sum.
REQ-014 SHALL have port upd_ready, output, 1 bit: high only in IDLE.
REQ-015 SHALL have port act_ctl, input, NCH bits: per-channel reload to START_OFF and soft-start entry.
REQ-016 SHALL have port off_div, output, NCH*CNT_WIDTH bits: channel k in bits [k*CNT_WIDTH +: CNT_WIDTH].
REQ-017 SHALL have port done_valid, output, 1 bit: one-cycle pulse when an update is written.
REQ-018 SHALL have port done_ch, output, CW bits: channel written, valid with done_valid.
REQ-019 SHALL have port err, output, 1 bit: one-cycle pulse when a request with upd_ch >= NCH is dropped.
REQ-020 SHALL have port ss_active, output, NCH bits: per-channel soft-start flags.

Function
REQ-021 SHALL implement FSM IDLE -> CALC -> CLAMP -> WRITE -> IDLE, one cycle per non-IDLE state.
REQ-022 SHALL accept a request on a clk edge with upd_valid=1 and upd_ready=1, capturing upd_ch and sum.
REQ-023 SHALL, on accept with upd_ch >= NCH, stay in IDLE, pulse err the next cycle, and change no state.
REQ-024 SHALL compute in CALC: mag = |sum| >> SHIFT, with |most-negative| saturating to the all-ones magnitude.
REQ-025 SHALL limit step = min(mag, SS_STEP) if ss_active[ch] is set, else min(mag, MAX_STEP).
REQ-026 SHALL form raw = off_div[ch] - step if sum < 0, else off_div[ch] + step, in CNT_WIDTH+2 signed bits with no wrap.
REQ-027 SHALL clamp in CLAMP: raw < MIN_OFF -> MIN_OFF; raw >= TOTAL_TIME -> TOTAL_TIME-1.
REQ-028 SHALL write the clamped value to off_div[ch] in WRITE, with done_valid=1 and done_ch=ch on the same cycle as the write.
REQ-029 SHALL, when act_ctl[k] is high on an edge, load off_div[k]=START_OFF and set ss_active[k].
REQ-030 SHALL give act_ctl[k] priority over a coincident WRITE to channel k; the write is discarded and done_valid still pulses.
REQ-031 SHALL clear ss_active[ch] in WRITE when mag < SS_STEP, unless act_ctl[ch] is high in that cycle.
REQ-032 SHALL latency: accept at edge N; off_div and done_valid update at edge N+3; next accept no earlier than edge N+3.
REQ-033 SHALL leave channels other than ch unchanged by an update, except through act_ctl.
REQ-034 SHALL treat sum = 0 as a non-negative sum with step 0, so off_div is unchanged.

Reset
REQ-035 SHALL, on rst=1 at any time including mid-update, immediately force state=IDLE, all off_div=START_OFF, ss_active all 1, done_valid=0, done_ch=0, err=0, and abandon any pending update.
REQ-036 SHALL assert upd_ready=1 in reset and in the first cycle after rst falls.

Verification
REQ-037 SHALL test: reset, then release rst -> every off_div=100, ss_active=4'hF, upd_ready=1.
REQ-038 SHALL test: clear ss_active on ch1 (sum=0 -> mag 0 < 2 clears it), then sum=+20480 on ch1 -> mag 20, off_div[1]=120 exactly 3 cycles after accept, done_ch=1.
REQ-039 SHALL test: ch0 in soft-start, sum=-1048576 -> off_div[0]=98; ss_active[0] stays 1.
REQ-040 SHALL test: ch2 non-soft-start at 390, sum=+2^30 -> step 64, clamps to off_div[2]=399; at 30 with sum=-2^30 -> off_div[2]=1.
REQ-041 SHALL test: upd_ch=5 with NCH=4 -> err pulse, off_div unchanged; act_ctl[3] asserted in the WRITE cycle of a ch3 update -> off_div[3]=100 and ss_active[3]=1.
REQ-042 SHALL test: rst asserted in CLAMP -> no write, no done_valid, off_div=100 on all channels.

Source files
------------

// File: rtl/pwm_ctl_mc.sv
// Multi-channel PWM off-time controller: a shared update pipeline that turns a
// signed error sum into a limited step applied to one channel's clamped off-time.
module pwm_ctl_mc #(
    parameter int NCH        = 4,
    parameter int CNT_WIDTH  = 18,
    parameter int SUM_WIDTH  = 37,
    parameter int SHIFT      = 10,
    parameter int MAX_STEP   = 64,
    parameter int SS_STEP    = 2,
    parameter int START_OFF  = 100,
    parameter int MIN_OFF    = 1,
    parameter int TOTAL_TIME = 400,
    localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     upd_valid,
    input  logic [CW-1:0]            upd_ch,
    input  logic [SUM_WIDTH-1:0]     sum,
    output logic                     upd_ready,
    input  logic [NCH-1:0]           act_ctl,
    output logic [NCH*CNT_WIDTH-1:0] off_div,
    output logic                     done_valid,
    output logic [CW-1:0]            done_ch,
    output logic                     err,
    output logic [NCH-1:0]           ss_active
);

    localparam int MW = SUM_WIDTH - 1;
    localparam int RW = CNT_WIDTH + 2;

    localparam logic [CW:0]               L_NCH    = (CW+1)'(NCH);
    localparam logic [MW-1:0]             L_SS     = MW'(SS_STEP);
    localparam logic [MW-1:0]             L_MAX    = MW'(MAX_STEP);
    localparam logic [CNT_WIDTH-1:0]      L_START  = CNT_WIDTH'(START_OFF);
    localparam logic signed [RW-1:0]      L_MIN    = RW'(MIN_OFF);
    localparam logic signed [RW-1:0]      L_TOT    = RW'(TOTAL_TIME);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_CLAMP, S_WRITE} state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [CNT_WIDTH-1:0]         r_off [NCH];
    logic [NCH-1:0]               r_ss;
    logic                         r_done_valid;
    logic [CW-1:0]                r_done_ch;
    logic                         r_err;

    logic [CW-1:0]                r_ch_p0;
    logic signed [SUM_WIDTH-1:0]  r_sum_p0;
    logic signed [RW-1:0]         r_raw_p1;
    logic                         r_ssclr_p1;
    logic [CNT_WIDTH-1:0]         r_new_p2;

    logic                         w_acc;
    logic                         w_bad;
    logic [MW-1:0]                w_mag;
    logic [MW-1:0]                w_lim;
    logic [MW-1:0]                w_step;
    logic signed [RW-1:0]         w_step_s;
    logic signed [RW-1:0]         w_cur;
    logic signed [RW-1:0]         w_raw;

    // |v| in MW bits; the most-negative value has no positive twin and saturates.
    function automatic logic [MW-1:0] f_abs_sat(input logic signed [SUM_WIDTH-1:0] v);
        if (v[SUM_WIDTH-1] && (v[MW-1:0] == '0))
            return '1;
        else if (v[SUM_WIDTH-1])
            return MW'(-v);
        else
            return MW'(v);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] f_clamp(input logic signed [RW-1:0] v);
        if (v < L_MIN)
            return CNT_WIDTH'(MIN_OFF);
        else if (v >= L_TOT)
            return CNT_WIDTH'(TOTAL_TIME - 1);
        else
            return CNT_WIDTH'(v);
    endfunction

    assign upd_ready  = (r_state == S_IDLE);
    assign w_acc      = upd_valid && upd_ready;
    assign w_bad      = ({1'b0, upd_ch} >= L_NCH);
    assign done_valid = r_done_valid;
    assign done_ch    = r_done_ch;
    assign err        = r_err;
    assign ss_active  = r_ss;

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_out
            assign off_div[g*CNT_WIDTH +: CNT_WIDTH] = r_off[g];
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_acc && !w_bad) w_state_nxt = S_CALC;
            S_CALC:  w_state_nxt = S_CLAMP;
            S_CLAMP: w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_mag    = f_abs_sat(r_sum_p0) >> SHIFT;
        w_lim    = r_ss[r_ch_p0] ? L_SS : L_MAX;
        w_step   = (w_mag < w_lim) ? w_mag : w_lim;
        w_step_s = RW'(w_step);
        w_cur    = $signed({2'b00, r_off[r_ch_p0]});
        w_raw    = r_sum_p0[SUM_WIDTH-1] ? (w_cur - w_step_s) : (w_cur + w_step_s);
    end

    // p0: request capture
    always_ff @(posedge clk) begin
        if (w_acc && !w_bad) begin
            r_ch_p0  <= upd_ch;
            r_sum_p0 <= $signed(sum);
        end
    end

    // p1: step applied, p2: clamped result
    always_ff @(posedge clk) begin
        if (r_state == S_CALC) begin
            r_raw_p1   <= w_raw;
            r_ssclr_p1 <= (w_mag < L_SS);
        end
        if (r_state == S_CLAMP)
            r_new_p2 <= f_clamp(r_raw_p1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ss         <= '1;
            r_done_valid <= 1'b0;
            r_done_ch    <= '0;
            r_err        <= 1'b0;
            for (int k = 0; k < NCH; k++)
                r_off[k] <= L_START;
        end else begin
            r_state      <= w_state_nxt;
            r_err        <= w_acc && w_bad;
            r_done_valid <= (r_state == S_WRITE);
            if (r_state == S_WRITE)
                r_done_ch <= r_ch_p0;
            // A reload on act_ctl wins over a coincident write to the same channel.
            for (int k = 0; k < NCH; k++) begin
                if (act_ctl[k]) begin
                    r_off[k] <= L_START;
                    r_ss[k]  <= 1'b1;
                end else if ((r_state == S_WRITE) && (r_ch_p0 == CW'(k))) begin
                    r_off[k] <= r_new_p2;
                    if (r_ssclr_p1)
                        r_ss[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_ctl_mc.sv
// Directed bench for pwm_ctl_mc: hand-computed off-time updates, clamps,
// soft-start behaviour, reloads, invalid-channel errors and mid-update reset.
module tb_pwm_ctl_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        upd_valid;
    logic [1:0]  upd_ch;
    logic [36:0] sum;
    logic        upd_ready;
    logic [3:0]  act_ctl;
    logic [71:0] off_div;
    logic        done_valid;
    logic [1:0]  done_ch;
    logic        err;
    logic [3:0]  ss_active;

    // Second instance with a non-power-of-two channel count so that an
    // out-of-range channel number is representable on upd_ch.
    logic        e_upd_valid;
    logic [2:0]  e_upd_ch;
    logic [36:0] e_sum;
    logic        e_upd_ready;
    logic [4:0]  e_act_ctl;
    logic [89:0] e_off_div;
    logic        e_done_valid;
    logic [2:0]  e_done_ch;
    logic        e_err;
    logic [4:0]  e_ss_active;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_ctl_mc dut (
        .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ch(upd_ch), .sum(sum),
        .upd_ready(upd_ready), .act_ctl(act_ctl), .off_div(off_div),
        .done_valid(done_valid), .done_ch(done_ch), .err(err), .ss_active(ss_active)
    );

    pwm_ctl_mc #(.NCH(5)) dut_e (
        .clk(clk), .rst(rst), .upd_valid(e_upd_valid), .upd_ch(e_upd_ch), .sum(e_sum),
        .upd_ready(e_upd_ready), .act_ctl(e_act_ctl), .off_div(e_off_div),
        .done_valid(e_done_valid), .done_ch(e_done_ch), .err(e_err), .ss_active(e_ss_active)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] off(input int k);
        return 64'(off_div[k*18 +: 18]);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one update and return just after the edge that writes it.
    task automatic upd(input int ch, input longint s);
        upd_valid = 1'b1;
        upd_ch    = 2'(ch);
        sum       = 37'(s);
        cycle();
        upd_valid = 1'b0;
        cycle();
        cycle();
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; upd_valid = 1'b0; upd_ch = '0; sum = '0; act_ctl = '0;
        e_upd_valid = 1'b0; e_upd_ch = '0; e_sum = '0; e_act_ctl = '0;
        cycle();
        cycle();
        chk("ready_in_rst", 64'(upd_ready), 64'd1);
        rst = 1'b0;
        cycle();
        for (int k = 0; k < 4; k++) chk("off_after_rst", off(k), 64'd100);
        chk("ss_after_rst", 64'(ss_active), 64'hF);
        chk("ready_after_rst", 64'(upd_ready), 64'd1);
        chk("done_after_rst", 64'(done_valid), 64'd0);
        chk("err_after_rst", 64'(err), 64'd0);

        // sum=0 on ch1: no change, soft-start cleared
        upd(1, 0);
        chk("zero_done", 64'(done_valid), 64'd1);
        chk("zero_done_ch", 64'(done_ch), 64'd1);
        chk("zero_off1", off(1), 64'd100);
        chk("zero_ss", 64'(ss_active), 64'b1101);
        cycle();
        chk("done_pulse", 64'(done_valid), 64'd0);

        // +20480 on ch1: mag 20 -> 120, exactly three edges after accept
        upd_valid = 1'b1; upd_ch = 2'd1; sum = 37'd20480;
        cycle();
        upd_valid = 1'b0;
        chk("busy_ready", 64'(upd_ready), 64'd0);
        cycle();
        cycle();
        chk("lat_done_n2", 64'(done_valid), 64'd0);
        chk("lat_off1_n2", off(1), 64'd100);
        cycle();
        chk("lat_done_n3", 64'(done_valid), 64'd1);
        chk("lat_done_ch", 64'(done_ch), 64'd1);
        chk("lat_off1_n3", off(1), 64'd120);
        chk("lat_ready", 64'(upd_ready), 64'd1);

        // ch0 in soft-start: step limited to 2
        upd(0, -1048576);
        chk("ss_off0", off(0), 64'd98);
        chk("ss_keep0", 64'(ss_active[0]), 64'd1);
        // most-negative sum saturates, still limited to 2
        upd(0, -(64'sd1 <<< 36));
        chk("mostneg_off0", off(0), 64'd96);

        // ch2 out of soft-start, walk up to 390 then clamp high
        upd(2, 0);
        for (int i = 0; i < 4; i++) upd(2, 64'sd1 <<< 30);
        upd(2, 34816);
        chk("ch2_390", off(2), 64'd390);
        upd(2, 64'sd1 <<< 30);
        chk("ch2_clamp_hi", off(2), 64'd399);
        for (int i = 0; i < 5; i++) upd(2, -(64'sd1 <<< 30));
        upd(2, -50176);
        chk("ch2_30", off(2), 64'd30);
        upd(2, -(64'sd1 <<< 30));
        chk("ch2_clamp_lo", off(2), 64'd1);
        chk("iso_off0", off(0), 64'd96);
        chk("iso_off1", off(1), 64'd120);
        chk("iso_off3", off(3), 64'd100);
        chk("main_err_quiet", 64'(err), 64'd0);

        // invalid channel on the 5-channel instance
        e_upd_valid = 1'b1; e_upd_ch = 3'd5; e_sum = 37'd20480;
        cycle();
        e_upd_valid = 1'b0;
        chk("err_pulse", 64'(e_err), 64'd1);
        chk("err_ready", 64'(e_upd_ready), 64'd1);
        cycle();
        chk("err_clear", 64'(e_err), 64'd0);
        chk("err_no_done", 64'(e_done_valid), 64'd0);
        for (int k = 0; k < 5; k++) chk("err_off", 64'(e_off_div[k*18 +: 18]), 64'd100);

        // act_ctl[3] coincident with the write to ch3
        upd(3, 0);
        chk("ch3_ss_clr", 64'(ss_active[3]), 64'd0);
        upd_valid = 1'b1; upd_ch = 2'd3; sum = 37'd20480;
        cycle();
        upd_valid = 1'b0;
        cycle();
        cycle();
        act_ctl = 4'b1000;
        cycle();
        act_ctl = 4'b0000;
        chk("act_off3", off(3), 64'd100);
        chk("act_ss3", 64'(ss_active[3]), 64'd1);
        chk("act_done", 64'(done_valid), 64'd1);
        chk("act_done_ch", 64'(done_ch), 64'd3);

        // reload of an idle channel
        act_ctl = 4'b0010;
        cycle();
        act_ctl = 4'b0000;
        chk("reload_off1", off(1), 64'd100);
        chk("reload_ss1", 64'(ss_active[1]), 64'd1);

        // reset while the update sits in CLAMP
        upd_valid = 1'b1; upd_ch = 2'd0; sum = 37'd20480;
        cycle();
        upd_valid = 1'b0;
        cycle();
        rst = 1'b1;
        #1;
        chk("rst_ready", 64'(upd_ready), 64'd1);
        chk("rst_off0", off(0), 64'd100);
        chk("rst_off2", off(2), 64'd100);
        chk("rst_ss", 64'(ss_active), 64'hF);
        cycle();
        cycle();
        chk("rst_no_done", 64'(done_valid), 64'd0);
        rst = 1'b0;
        cycle();
        chk("post_rst_done", 64'(done_valid), 64'd0);
        for (int k = 0; k < 4; k++) chk("post_rst_off", off(k), 64'd100);
        chk("post_rst_ready", 64'(upd_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
